// File: rtl/sdf_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 SDF stage controllers.
package sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Feedback buffer depth of a stage.
  function automatic int depth(input int stage_no);
    return 1 << (stage_no - 1);
  endfunction

  function automatic int tw_shift(input int nfft, input int stage_no);
    return clog2(nfft) - stage_no;
  endfunction

endpackage

// File: rtl/sdf_valid_pipe.sv
// Fixed-depth shift register carrying {valid, last} alongside the stage datapath latency.
module sdf_valid_pipe #(
  parameter int OUT_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic occupied
);

  logic [OUT_LAT-1:0] vld_q, vld_d;
  logic [OUT_LAT-1:0] last_q, last_d;

  always_comb begin
    vld_d     = '0;
    last_d    = '0;
    vld_d[0]  = in_valid;
    last_d[0] = in_last;
    for (int i = 1; i < OUT_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign out_valid = vld_q[OUT_LAT-1];
  assign out_last  = last_q[OUT_LAT-1];
  assign occupied  = |vld_q;

endmodule

// File: rtl/sdf_r2_stage_ctrl.sv
// Frame-aware sequencer for one radix-2 SDF stage: mux select, twiddle address,
// frame tracking with back-to-back, flush and abort handling, and output framing.
module sdf_r2_stage_ctrl
  import sdf_pkg::*;
#(
  parameter int NFFT     = 64,
  parameter int STAGE_NO = 1,
  parameter int OUT_LAT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_conv,
  input  logic                    in_valid,
  output logic                    sel1,
  output logic [clog2(NFFT)-1:0]  tw_addr,
  output logic                    tw_active,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int L     = clog2(NFFT);
  localparam int D     = depth(STAGE_NO);
  localparam int TW_SH = tw_shift(NFFT, STAGE_NO);

  localparam logic [L-1:0] CNT_MAX = L'(NFFT - 1);
  localparam logic [L-1:0] D_LAST  = L'(D - 1);
  localparam logic [L-1:0] D_CNT   = L'(D);

  state_e         state_q, state_d;
  logic [L-1:0]   cnt_q, cnt_d;
  logic           first_q, first_d;
  logic           sel1_q, sel1_d;
  logic [L-1:0]   tw_addr_q, tw_addr_d;
  logic           tw_active_q, tw_active_d;
  logic           vld_raw_q, vld_raw_d;
  logic           last_raw_q, last_raw_d;
  logic           frame_err_q, frame_err_d;

  logic [L-1:0]   samp;
  logic           take;
  logic           in_flush;
  logic           pipe_occupied;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    frame_err_d = 1'b0;
    samp        = cnt_q;
    take        = 1'b0;
    in_flush    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_conv) begin
          if (in_valid) begin
            take    = 1'b1;
            samp    = '0;
            state_d = RUN;
            cnt_d   = L'(1);
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A missing sample aborts the frame; already-issued valids still drain.
        if (!in_valid) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
          first_d     = 1'b1;
        end else begin
          take  = 1'b1;
          cnt_d = cnt_q + L'(1);
          if (cnt_q == CNT_MAX) begin
            if (start_conv) first_d = 1'b0;
            else            state_d = FLUSH;
          end else if (start_conv) begin
            frame_err_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        in_flush    = 1'b1;
        frame_err_d = start_conv;
        if (cnt_q == D_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + L'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        first_d = 1'b1;
      end
    endcase

    // The first D samples of a frame only fill the feedback buffer unless a previous frame is draining.
    sel1_d      = take & samp[STAGE_NO-1];
    vld_raw_d   = in_flush | (take & ((samp >= D_CNT) | ~first_q));
    last_raw_d  = in_flush & (cnt_q == D_LAST);
    tw_active_d = vld_raw_d & ~sel1_d;
    tw_addr_d   = tw_active_d ? ((samp & D_LAST) << TW_SH) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      sel1_q      <= 1'b0;
      tw_addr_q   <= '0;
      tw_active_q <= 1'b0;
      vld_raw_q   <= 1'b0;
      last_raw_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      sel1_q      <= sel1_d;
      tw_addr_q   <= tw_addr_d;
      tw_active_q <= tw_active_d;
      vld_raw_q   <= vld_raw_d;
      last_raw_q  <= last_raw_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Registered decision, then OUT_LAT further stages to line up with the stage output register.
  sdf_valid_pipe #(
    .OUT_LAT(OUT_LAT)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (vld_raw_q),
    .in_last  (last_raw_q),
    .out_valid(out_valid),
    .out_last (out_last),
    .occupied (pipe_occupied)
  );

  assign sel1      = sel1_q;
  assign tw_addr   = tw_addr_q;
  assign tw_active = tw_active_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE) | vld_raw_q | pipe_occupied;

endmodule

// File: tb/tb_sdf_r2_stage_ctrl.sv
// Directed bench for sdf_r2_stage_ctrl with NFFT=64, STAGE_NO=3 (D=4), OUT_LAT=2.
module tb_sdf_r2_stage_ctrl;

  localparam int NFFT     = 64;
  localparam int STAGE_NO = 3;
  localparam int OUT_LAT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_conv;
  logic       in_valid;
  logic       sel1;
  logic [5:0] tw_addr;
  logic       tw_active;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  sdf_r2_stage_ctrl #(
    .NFFT    (NFFT),
    .STAGE_NO(STAGE_NO),
    .OUT_LAT (OUT_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_conv(start_conv),
    .in_valid  (in_valid),
    .sel1      (sel1),
    .tw_addr   (tw_addr),
    .tw_active (tw_active),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scn;
    int         cyc;
    logic       sel;
    logic [5:0] addr;
    logic       twa;
    logic       ov;
    logic       ol;
    logic       busy;
    logic       err;
  } vec_t;

  typedef struct {
    int errs;
    int lasts;
    int valids;
    int ncyc;
  } agg_t;

  vec_t tbl[$];
  agg_t agg[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int scn, input int cyc, input bit sel, input int addr,
                              input bit twa, input bit ov, input bit ol, input bit bsy, input bit err);
    vec_t v;
    v.scn  = scn;
    v.cyc  = cyc;
    v.sel  = sel;
    v.addr = 6'(addr);
    v.twa  = twa;
    v.ov   = ov;
    v.ol   = ol;
    v.busy = bsy;
    v.err  = err;
    tbl.push_back(v);
  endfunction

  // Scenario stimulus: 0 single, 1 back-to-back, 2 early start, 3 input gap, 4 start in flush.
  function automatic void stim(input int scn, input int c, output logic st, output logic vin);
    st = (c == 0) || (scn == 1 && c == 63) || (scn == 2 && c == 20) || (scn == 4 && c == 66);
    if (scn == 1)      vin = (c < 128);
    else if (scn == 3) vin = (c < 30);
    else               vin = (c < 64);
  endfunction

  task automatic do_reset();
    start_conv = 1'b0;
    in_valid   = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " sel1"}, sel1, 0);
    chk({tag, " tw_addr"}, tw_addr, 0);
    chk({tag, " tw_active"}, tw_active, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_err"}, frame_err, 0);
  endtask

  task automatic run_scenario(input int scn);
    int   errs;
    int   lasts;
    int   valids;
    logic st;
    logic vin;
    string tag;
    errs   = 0;
    lasts  = 0;
    valids = 0;
    for (int c = 0; c < agg[scn].ncyc; c++) begin
      foreach (tbl[k]) begin
        if (tbl[k].scn == scn && tbl[k].cyc == c) begin
          tag = $sformatf("s%0d c%0d", scn, c);
          chk({tag, " sel1"}, sel1, tbl[k].sel);
          chk({tag, " tw_addr"}, tw_addr, tbl[k].addr);
          chk({tag, " tw_active"}, tw_active, tbl[k].twa);
          chk({tag, " out_valid"}, out_valid, tbl[k].ov);
          chk({tag, " out_last"}, out_last, tbl[k].ol);
          chk({tag, " busy"}, busy, tbl[k].busy);
          chk({tag, " frame_err"}, frame_err, tbl[k].err);
        end
      end
      errs   += int'(frame_err);
      lasts  += int'(out_last);
      valids += int'(out_valid);
      stim(scn, c, st, vin);
      start_conv = st;
      in_valid   = vin;
      @(negedge clk);
    end
    start_conv = 1'b0;
    in_valid   = 1'b0;
    tag = $sformatf("s%0d", scn);
    chk({tag, " frame_err pulses"}, errs, agg[scn].errs);
    chk({tag, " out_last count"}, lasts, agg[scn].lasts);
    chk({tag, " out_valid count"}, valids, agg[scn].valids);
  endtask

  initial begin
    // scn, cyc, sel1, tw_addr, tw_active, out_valid, out_last, busy, frame_err
    add(0,  0, 0,  0, 0, 0, 0, 0, 0);
    add(0,  1, 0,  0, 0, 0, 0, 1, 0);
    add(0,  4, 0,  0, 0, 0, 0, 1, 0);
    add(0,  5, 1,  0, 0, 0, 0, 1, 0);
    add(0,  6, 1,  0, 0, 0, 0, 1, 0);
    add(0,  7, 1,  0, 0, 1, 0, 1, 0);
    add(0,  9, 0,  0, 1, 1, 0, 1, 0);
    add(0, 10, 0,  8, 1, 1, 0, 1, 0);
    add(0, 11, 0, 16, 1, 1, 0, 1, 0);
    add(0, 12, 0, 24, 1, 1, 0, 1, 0);
    add(0, 13, 1,  0, 0, 1, 0, 1, 0);
    add(0, 57, 0,  0, 1, 1, 0, 1, 0);
    add(0, 64, 1,  0, 0, 1, 0, 1, 0);
    add(0, 65, 0,  0, 1, 1, 0, 1, 0);
    add(0, 66, 0,  8, 1, 1, 0, 1, 0);
    add(0, 67, 0, 16, 1, 1, 0, 1, 0);
    add(0, 68, 0, 24, 1, 1, 0, 1, 0);
    add(0, 69, 0,  0, 0, 1, 0, 1, 0);
    add(0, 70, 0,  0, 0, 1, 1, 1, 0);
    add(0, 71, 0,  0, 0, 0, 0, 0, 0);

    add(1,  64, 1,  0, 0, 1, 0, 1, 0);
    add(1,  65, 0,  0, 1, 1, 0, 1, 0);
    add(1,  66, 0,  8, 1, 1, 0, 1, 0);
    add(1,  68, 0, 24, 1, 1, 0, 1, 0);
    add(1,  69, 1,  0, 0, 1, 0, 1, 0);
    add(1,  70, 1,  0, 0, 1, 0, 1, 0);
    add(1, 128, 1,  0, 0, 1, 0, 1, 0);
    add(1, 129, 0,  0, 1, 1, 0, 1, 0);
    add(1, 132, 0, 24, 1, 1, 0, 1, 0);
    add(1, 134, 0,  0, 0, 1, 1, 1, 0);
    add(1, 135, 0,  0, 0, 0, 0, 0, 0);

    add(2, 20, 0, 24, 1, 1, 0, 1, 0);
    add(2, 21, 1,  0, 0, 1, 0, 1, 1);
    add(2, 22, 1,  0, 0, 1, 0, 1, 0);
    add(2, 25, 0,  0, 1, 1, 0, 1, 0);
    add(2, 70, 0,  0, 0, 1, 1, 1, 0);
    add(2, 71, 0,  0, 0, 0, 0, 0, 0);

    add(3, 30, 1,  0, 0, 1, 0, 1, 0);
    add(3, 31, 0,  0, 0, 1, 0, 1, 1);
    add(3, 32, 0,  0, 0, 1, 0, 1, 0);
    add(3, 33, 0,  0, 0, 0, 0, 0, 0);
    add(3, 70, 0,  0, 0, 0, 0, 0, 0);

    add(4, 66, 0,  8, 1, 1, 0, 1, 0);
    add(4, 67, 0, 16, 1, 1, 0, 1, 1);
    add(4, 68, 0, 24, 1, 1, 0, 1, 0);
    add(4, 70, 0,  0, 0, 1, 1, 1, 0);
    add(4, 71, 0,  0, 0, 0, 0, 0, 0);

    // errs, lasts, valids, cycles run
    agg[0] = '{0, 1,  64,  80};
    agg[1] = '{0, 1, 128, 140};
    agg[2] = '{1, 1,  64,  80};
    agg[3] = '{1, 0,  26,  80};
    agg[4] = '{1, 1,  64,  80};

    do_reset();
    check_outputs_zero("reset");

    // start without a sample while idle
    start_conv = 1'b1;
    in_valid   = 1'b0;
    @(negedge clk);
    start_conv = 1'b0;
    chk("idle start no data frame_err", frame_err, 1);
    chk("idle start no data busy", busy, 0);
    @(negedge clk);
    chk("idle start no data frame_err clears", frame_err, 0);
    chk("idle start no data stays idle", busy, 0);

    for (int s = 0; s < 5; s++) begin
      do_reset();
      run_scenario(s);
    end

    // asynchronous reset between clock edges in the middle of a frame
    do_reset();
    start_conv = 1'b1;
    in_valid   = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrun pre sel1", sel1, 1);
    chk("midrun pre out_valid", out_valid, 1);
    chk("midrun pre busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async reset");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("after release");
    run_scenario(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
